bcd_step_counter: RTL and testbench

- Sequential source stage that feeds the active-low two-digit 7-segment decoder.
- Takes two raw pushbuttons (up/down) and a 4-bit switch bank with a load strobe.
- Synchronizes and debounces each button, then converts each clean press into a single count step.
- Holds a 4-bit wrap-around count on outputs w,x,y,z, which wire directly to the decoder inputs of the same names (w = MSB, z = LSB).

---
 rtl/bcd_step_counter.sv | 158 +++++++++++++++
 tb/tb_bcd_step_counter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_step_counter.sv
// bcd_step_counter: synchronizes and debounces two pushbuttons, turns each
// accepted press into a single up/down step on a 4-bit wrap-around count,
// and supports a synchronous parallel load from a switch bank.
// Outputs w,x,y,z (w = MSB) feed the downstream two-digit 7-segment decoder.

module bcd_step_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic db_o
);

  // Terminal count: the level must differ from db for CYCLES consecutive edges.
  localparam logic [23:0] TERM = 24'(CYCLES - 1);

  logic [23:0] cnt_q;
  logic        db_q;

  // Accept a new level only after it has held steadily; any return to the
  // accepted level restarts the qualification from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (in_i == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM) begin
      db_q  <= in_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

  assign db_o = db_q;

endmodule

module bcd_step_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          SIM_FAST        = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       load,
  input  logic [3:0] sw,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       ovf,
  output logic       unf
);

  // SIM_FAST only records that the bench shortened the debounce window.
  if (SIM_FAST) begin : g_sim_fast
  end

  // Bit layout of the synchronized bus: {sw[3:0], load, btn_dn, btn_up}.
  logic [6:0] raw;
  logic [6:0] s1_q;
  logic [6:0] s2_q;

  assign raw = {sw, load, btn_dn, btn_up};

  // Two-flop synchronizer for every asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  logic db_up;
  logic db_dn;

  bcd_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .in_i  (s2_q[0]),
    .db_o  (db_up)
  );

  bcd_step_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk   (clk),
    .reset (reset),
    .in_i  (s2_q[1]),
    .db_o  (db_dn)
  );

  // Delayed copies of the debounced levels for rising-edge detection.
  logic [1:0] db_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_d_q <= '0;
    end else begin
      db_d_q <= {db_dn, db_up};
    end
  end

  logic step_up;
  logic step_dn;
  logic load_s2;
  logic [3:0] sw_s2;

  assign step_up = db_up & ~db_d_q[0];
  assign step_dn = db_dn & ~db_d_q[1];
  assign load_s2 = s2_q[2];
  assign sw_s2   = s2_q[6:3];

  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;

  // Next count: load wins, simultaneous steps cancel, wraps flag ovf/unf.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load_s2) begin
      count_d = sw_s2;
    end else if (step_up && step_dn) begin
      count_d = count_q;
    end else if (step_up) begin
      count_d = count_q + 4'd1;
      ovf_d   = (count_q == 4'd15);
    end else if (step_dn) begin
      count_d = count_q - 4'd1;
      unf_d   = (count_q == 4'd0);
    end
  end

  // Registered count and wrap pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign {w, x, y, z} = count_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter with DEBOUNCE_CYCLES = 4.
// Observed vector is {w,x,y,z,ovf,unf}; inputs change 1 ns after posedge
// and outputs are sampled at the same point.

module tb_bcd_step_counter;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_dn;
  logic       load;
  logic [3:0] sw;
  logic       w, x, y, z, ovf, unf;

  int pass_cnt;
  int total_cnt;

  logic [5:0] obs;
  assign obs = {w, x, y, z, ovf, unf};

  bcd_step_counter #(
    .DEBOUNCE_CYCLES (4),
    .SIM_FAST        (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .load   (load),
    .sw     (sw),
    .w      (w),
    .x      (x),
    .y      (y),
    .z      (z),
    .ovf    (ovf),
    .unf    (unf)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    load   = 1'b0;
    sw     = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_load(input logic [3:0] val);
    sw   = val;
    load = 1'b1;
    repeat (3) tick();
    load = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    reset  = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    load   = 1'b0;
    sw     = 4'd0;
    repeat (3) tick();
    exp = 6'b0000_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_state got=%b exp=%b", obs, exp);
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp) $display("FAIL idle_cycle%0d got=%b exp=%b", i, obs, exp);
      else pass_cnt++;
    end
    do_load(4'b0111);
    exp = 6'b0111_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL load7 got=%b exp=%b", obs, exp);
    else pass_cnt++;
    // Mid-cycle asynchronous reset must clear before the next edge.
    #3;
    reset = 1'b1;
    #1;
    exp = 6'b0000_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL async_reset got=%b exp=%b", obs, exp);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    logic [5:0] exp;
    apply_reset();
    btn_up = 1'b1;
    repeat (6) tick();
    exp = 6'b0000_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL pre_step_edge6 got=%b exp=%b", obs, exp);
    else pass_cnt++;
    tick();
    exp = 6'b0001_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL step_edge7 got=%b exp=%b", obs, exp);
    else pass_cnt++;
    for (int i = 0; i < 50; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp) $display("FAIL held_no_repeat%0d got=%b exp=%b", i, obs, exp);
      else pass_cnt++;
    end
    btn_up = 1'b0;
    repeat (10) tick();
    btn_up = 1'b1;
    repeat (10) tick();
    exp = 6'b0010_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL second_press got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_up = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    logic [5:0] exp;
    logic [4:0] pat;
    apply_reset();
    pat = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      btn_up = pat[i];
      tick();
    end
    btn_up = 1'b1;
    repeat (6) tick();
    exp = 6'b0000_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL bounce_pre_step got=%b exp=%b", obs, exp);
    else pass_cnt++;
    tick();
    exp = 6'b0001_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL bounce_step_edge7 got=%b exp=%b", obs, exp);
    else pass_cnt++;
    repeat (10) tick();
    total_cnt++;
    if (obs !== exp) $display("FAIL bounce_single_step got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_up = 1'b0;
    repeat (10) tick();
    // A 3-cycle pulse is shorter than the debounce window.
    btn_up = 1'b1;
    repeat (3) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    total_cnt++;
    if (obs !== exp) $display("FAIL short_pulse_ignored got=%b exp=%b", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [5:0] exp;
    apply_reset();
    do_load(4'b1111);
    exp = 6'b1111_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL load15 got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_up = 1'b1;
    repeat (6) tick();
    total_cnt++;
    if (obs !== exp) $display("FAIL pre_ovf got=%b exp=%b", obs, exp);
    else pass_cnt++;
    tick();
    exp = 6'b0000_10;
    total_cnt++;
    if (obs !== exp) $display("FAIL ovf_wrap got=%b exp=%b", obs, exp);
    else pass_cnt++;
    tick();
    exp = 6'b0000_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL ovf_one_cycle got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_up = 1'b0;
    repeat (10) tick();
    btn_dn = 1'b1;
    repeat (7) tick();
    exp = 6'b1111_01;
    total_cnt++;
    if (obs !== exp) $display("FAIL unf_wrap got=%b exp=%b", obs, exp);
    else pass_cnt++;
    tick();
    exp = 6'b1111_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL unf_one_cycle got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_dn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    apply_reset();
    do_load(4'b0101);
    exp = 6'b0101_00;
    btn_up = 1'b1;
    btn_dn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp) $display("FAIL both_pressed%0d got=%b exp=%b", i, obs, exp);
      else pass_cnt++;
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_load_blocks_step();
    logic [5:0] exp;
    apply_reset();
    sw     = 4'b1001;
    load   = 1'b1;
    btn_up = 1'b1;
    repeat (3) tick();
    exp = 6'b1001_00;
    for (int i = 0; i < 12; i++) begin
      tick();
      total_cnt++;
      if (obs !== exp) $display("FAIL load_hold%0d got=%b exp=%b", i, obs, exp);
      else pass_cnt++;
    end
    load = 1'b0;
    repeat (10) tick();
    total_cnt++;
    if (obs !== exp) $display("FAIL after_load_no_step got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_up = 1'b0;
    repeat (10) tick();
    total_cnt++;
    if (obs !== exp) $display("FAIL release_no_step got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_dn = 1'b1;
    repeat (7) tick();
    exp = 6'b1000_00;
    total_cnt++;
    if (obs !== exp) $display("FAIL down_after_load got=%b exp=%b", obs, exp);
    else pass_cnt++;
    btn_dn = 1'b0;
    repeat (10) tick();
  endtask

  // Test sequence and final report
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_simultaneous();
    test_load_blocks_step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
